// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer for the 32-byte big-endian data memory
// Optional alignment checking is enabled by defining MAU_ALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_stype,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LD   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       cap_q, cap_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              misalign;
    logic              req_bad;
    logic [31:0]       ld_data;

    always_comb begin
`ifdef MAU_ALIGN_CHECK_EN
        misalign = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_bad = (req_size == 2'b11) || misalign;
    end

    // Memory returns the addressed byte in the top lane, so narrow loads take the MSBs.
    always_comb begin
        case (size_q)
            2'b00:   ld_data = {{24{~uns_q & mem_rdata[31]}}, mem_rdata[31:24]};
            2'b01:   ld_data = {{16{~uns_q & mem_rdata[31]}}, mem_rdata[31:16]};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_bad) begin
                        state_d = S_RESP;
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d = S_LD;
                    end else if (req_size == 2'b01) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_LD: begin
                state_d = S_RESP;
                rdata_d = ld_data;
                err_d   = 1'b0;
            end
            S_RD: begin
                // Bytes addr+2..addr+3 are preserved by the 4-byte write that follows.
                cap_d   = mem_rdata[15:0];
                state_d = S_WR;
            end
            S_WR: begin
                state_d = S_RESP;
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            cap_q   <= 16'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory-side outputs decode straight from state so reset kills mem_we without a clock.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_we     = (state_q == S_WR);
        mem_stype  = (state_q == S_WR) && (size_q == 2'b00);
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        if ((state_q == S_LD) || (state_q == S_RD) || (state_q == S_WR)) mem_addr = addr_q;
        if (state_q == S_WR) begin
            case (size_q)
                2'b00:   mem_wdata = {24'h0, wdata_q[7:0]};
                2'b01:   mem_wdata = {wdata_q[15:0], cap_q};
                default: mem_wdata = wdata_q;
            endcase
        end
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with a byte-array memory model
module tb_mem_access_unit;

`ifdef MAU_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [4:0]  req_addr = 5'd0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic        mem_stype;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_unit #(.ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_stype(mem_stype),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [32] = '{default: 8'h00};
    assign mem_rdata = {mem[mem_addr], mem[mem_addr + 5'd1], mem[mem_addr + 5'd2], mem[mem_addr + 5'd3]};

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_stype) begin
                mem[mem_addr] <= mem_wdata[7:0];
            end else begin
                mem[mem_addr]        <= mem_wdata[31:24];
                mem[mem_addr + 5'd1] <= mem_wdata[23:16];
                mem[mem_addr + 5'd2] <= mem_wdata[15:8];
                mem[mem_addr + 5'd3] <= mem_wdata[7:0];
            end
        end
    end

    int we_cnt = 0;
    always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] mem_word(input logic [4:0] a);
        logic [4:0] a1, a2, a3;
        a1 = a + 5'd1; a2 = a + 5'd2; a3 = a + 5'd3;
        return {mem[a], mem[a1], mem[a2], mem[a3]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t vt[$];

    task automatic do_req(input vec_t v);
        int   lat;
        int   guard;
        int   we0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("%s accept", v.name), {31'b0, req_ready}, 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        we0 = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat, v.exp_we, v.name});
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check($sformatf("%s rdata", e.name), resp_rdata, e.rdata);
        check($sformatf("%s err", e.name), {31'b0, resp_err}, {31'b0, e.err});
        check($sformatf("%s latency", e.name), lat, e.lat);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check($sformatf("%s we_cycles", e.name), we_cnt - we0, e.we);
    endtask

    task automatic wait_resp(input string name);
        int guard;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("%s resp_timeout", name), {31'b0, resp_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt.push_back('{1'b1, 2'b10, 1'b0, 5'd4,  32'hDEADBEEF, 32'h0, 1'b0, 2, 1, "sw_word4"});
        vt.push_back('{1'b0, 2'b10, 1'b0, 5'd4,  32'h0, 32'hDEADBEEF, 1'b0, 2, 0, "lw_word4"});
        vt.push_back('{1'b1, 2'b00, 1'b0, 5'd5,  32'hFFFFFF80, 32'h0, 1'b0, 2, 1, "sb_byte5"});
        vt.push_back('{1'b0, 2'b00, 1'b0, 5'd5,  32'h0, 32'hFFFFFF80, 1'b0, 2, 0, "lb_signed5"});
        vt.push_back('{1'b0, 2'b00, 1'b1, 5'd5,  32'h0, 32'h00000080, 1'b0, 2, 0, "lb_unsigned5"});
        vt.push_back('{1'b0, 2'b10, 1'b1, 5'd4,  32'h0, 32'hDE80BEEF, 1'b0, 2, 0, "lw_after_sb"});
        vt.push_back('{1'b1, 2'b10, 1'b0, 5'd8,  32'hAABBCCDD, 32'h0, 1'b0, 2, 1, "sw_word8"});
        vt.push_back('{1'b1, 2'b01, 1'b0, 5'd8,  32'hFFFF1234, 32'h0, 1'b0, 3, 1, "sh_half8"});
        vt.push_back('{1'b0, 2'b10, 1'b0, 5'd8,  32'h0, 32'h1234CCDD, 1'b0, 2, 0, "lw_after_sh"});
        vt.push_back('{1'b0, 2'b01, 1'b0, 5'd8,  32'h0, 32'h00001234, 1'b0, 2, 0, "lh_signed8"});
        vt.push_back('{1'b0, 2'b01, 1'b0, 5'd4,  32'h0, 32'hFFFFDE80, 1'b0, 2, 0, "lh_signed4"});
        vt.push_back('{1'b0, 2'b01, 1'b1, 5'd4,  32'h0, 32'h0000DE80, 1'b0, 2, 0, "lh_unsigned4"});
        vt.push_back('{1'b1, 2'b11, 1'b0, 5'd0,  32'h12345678, 32'h0, 1'b1, 1, 0, "size11_store"});
        vt.push_back('{1'b0, 2'b11, 1'b0, 5'd4,  32'h0, 32'h0, 1'b1, 1, 0, "size11_load"});
        vt.push_back('{1'b1, 2'b10, 1'b0, 5'd30, 32'h11223344, 32'h0, ALN, ALN ? 1 : 2, ALN ? 0 : 1, "sw_wrap30"});
        vt.push_back('{1'b0, 2'b10, 1'b0, 5'd30, 32'h0, ALN ? 32'h0 : 32'h11223344, ALN, ALN ? 1 : 2, 0, "lw_wrap30"});
        vt.push_back('{1'b0, 2'b01, 1'b0, 5'd5,  32'h0, ALN ? 32'h0 : 32'hFFFF80BE, ALN, ALN ? 1 : 2, 0, "lh_odd5"});

        // Reset state while rst is held low.
        repeat (2) @(negedge clk);
        check("rst req_ready",  {31'b0, req_ready},  32'd1);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst resp_err",   {31'b0, resp_err},   32'd0);
        check("rst busy",       {31'b0, busy},       32'd0);
        check("rst mem_we",     {31'b0, mem_we},     32'd0);
        check("rst mem_stype",  {31'b0, mem_stype},  32'd0);
        check("rst mem_addr",   {27'b0, mem_addr},   32'd0);
        check("rst mem_wdata",  mem_wdata, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) do_req(vt[i]);

        check("mem word4",  mem_word(5'd4), 32'hDE80BEEF);
        check("mem word8",  mem_word(5'd8), 32'h1234CCDD);
        check("mem byte30", {24'b0, mem[30]}, ALN ? 32'h0 : 32'h11);
        check("mem byte0",  {24'b0, mem[0]},  ALN ? 32'h0 : 32'h33);
        check("mem byte1",  {24'b0, mem[1]},  ALN ? 32'h0 : 32'h44);

        // Back-pressure: response held while a second request waits.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 5'd4;
        @(posedge clk);
        #1;
        req_size = 2'b00; req_unsigned = 1'b1; req_addr = 5'd7;
        @(negedge clk);
        wait_resp("bp first");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp hold%0d resp_valid", i), {31'b0, resp_valid}, 32'd1);
            check($sformatf("bp hold%0d rdata", i), resp_rdata, 32'hDE80BEEF);
            check($sformatf("bp hold%0d req_ready", i), {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check("bp after_hs req_ready", {31'b0, req_ready}, 32'd1);
        check("bp after_hs busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("bp second accepted", {31'b0, busy}, 32'd1);
        @(negedge clk);
        wait_resp("bp second");
        check("bp second rdata", resp_rdata, 32'h000000EF);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;

        // Reset during WR of a word store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 5'd12; req_wdata = 32'h55667788;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("abort_wr mem_we before", {31'b0, mem_we}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("abort_wr mem_we",     {31'b0, mem_we},     32'd0);
        check("abort_wr busy",       {31'b0, busy},       32'd0);
        check("abort_wr req_ready",  {31'b0, req_ready},  32'd1);
        check("abort_wr resp_rdata", resp_rdata, 32'h0);
        check("abort_wr mem_addr",   {27'b0, mem_addr},   32'd0);
        check("abort_wr mem_wdata",  mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        check("abort_wr mem word12", mem_word(5'd12), 32'h0);
        do_req('{1'b0, 2'b10, 1'b0, 5'd4, 32'h0, 32'hDE80BEEF, 1'b0, 2, 0, "lw_after_abort"});

        // Reset during RD of a half store leaves memory untouched.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 5'd8; req_wdata = 32'h0000FFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("abort_rd mem_we",   {31'b0, mem_we},   32'd0);
        check("abort_rd mem_addr", {27'b0, mem_addr}, 32'd8);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rd mem word8", mem_word(5'd8), 32'h1234CCDD);
        do_req('{1'b1, 2'b00, 1'b0, 5'd9, 32'h000000A5, 32'h0, 1'b0, 2, 1, "sb_after_abort"});
        check("mem word8 final", mem_word(5'd8), 32'h12A5CCDD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the control unit and the 32-byte data memory. Accepts one load or store request through a valid/ready handshake and drives the memory's address, write-enable, store-type and data lines. Byte and word stores take a single memory cycle; halfword stores use a read-modify-write. Loads return a sign- or zero-extended result through a valid/ready response channel.

## Interface
- ADDR_W, 5, byte-address width; memory is 2^ADDR_W bytes, big-endian (lowest address = MSB).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request rejected.
- busy  out  1  state != IDLE.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_stype  out  1  1 = byte write of mem_wdata[7:0] at mem_addr; 0 = 4-byte write.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational memory read, bytes mem_addr..mem_addr+3 with MSB first.

## Operation
- States: IDLE, LD, RD, WR, RESP. req_ready = (state == IDLE).
- Accept on req_valid & req_ready; all req_* fields latched into internal registers at that edge.
- IDLE → RESP with resp_err=1 on size 11 (or on misalignment, see Configuration); no memory access.
- Load: IDLE → LD → RESP. In LD, mem_addr = latched address, mem_we=0; result captured at end of LD.
  - byte: mem_rdata[31:24], half: mem_rdata[31:16], word: mem_rdata. Extended to 32 bits per req_unsigned. Word ignores req_unsigned.
- Store byte: IDLE → WR → RESP. In WR: mem_we=1, mem_stype=1, mem_wdata = {24'b0, wdata[7:0]}.
- Store word: IDLE → WR → RESP. In WR: mem_we=1, mem_stype=0, mem_wdata = wdata.
- Store half: IDLE → RD → WR → RESP. In RD: mem_we=0 and mem_rdata[15:0] is captured. In WR: mem_we=1, mem_stype=0, mem_wdata = {wdata[15:0], captured[15:0]}.
- RESP: resp_valid=1 and held stable until resp_ready; then RESP → IDLE on the same edge. No new request is accepted in RESP.
- Address arithmetic is modulo 2^ADDR_W: an access at 30 covers bytes 30, 31, 0, 1.
- mem_addr, mem_wdata, mem_stype are 0 whenever state is IDLE or RESP. mem_we is 1 only in WR.

## Timing
- Reset (rst=0, asynchronous): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; busy=0; mem_we=0; mem_stype=0; mem_addr=0; mem_wdata=0.
- Latency from accept edge to resp_valid: load 2 cycles, byte/word store 2 cycles, half store 3 cycles, error 1 cycle.
- Reset asserted mid-operation aborts immediately, and mem_we drops without waiting for a clock. If a half store is aborted in RD, memory is unchanged.
- resp_rdata and resp_err are registered and change only on entry to RESP.

## Configuration
- MAU_ALIGN_CHECK_EN defined: a half access at an odd address, or a word access at an address not ≡ 0 mod 4, produces an error response (resp_err=1, resp_rdata=0) with no memory access.
- Not defined: no alignment check. Misaligned accesses proceed with modulo wrap-around.

## Test plan
- Word store 0xDEADBEEF at addr 4, then word load at 4 → mem bytes 4..7 = DE AD BE EF; load resp_rdata=0xDEADBEEF; each response arrives 2 cycles after accept.
- Byte store 0x80 at addr 5 over 0xDEADBEEF, then signed byte load at 5 → 0xFFFFFF80; unsigned load → 0x00000080; word at 4 = 0xDE80BEEF.
- Half store 0x1234 at addr 8 over 0xAABBCCDD → RD then WR seen on mem_*, word at 8 = 0x1234CCDD; response 3 cycles after accept; signed half load at 8 → 0x00001234.
- Size 11 request → resp_err=1 one cycle after accept, mem_we never asserted. Misaligned word at addr 30: with MAU_ALIGN_CHECK_EN → err; without → bytes 30, 31, 0, 1 written.
- resp_ready held 0 for 5 cycles in RESP → resp_valid and resp_rdata stable, req_ready=0, and a second req_valid is not accepted until the cycle after the handshake.
- rst pulsed low during WR of a word store → mem_we falls immediately, all outputs at reset values, and the next request completes normally.
